dir_qualifier: RTL and testbench
================================

# dir_qualifier

Conditions the raw joystick direction code from the PmodJSTK direction decoder into single, clean move requests for the game controller. It synchronizes the input, requires a direction to be stable before accepting it, and issues one move per deflection. The move is presented through a valid/ready handshake, and the stick must return to neutral before the next move is issued. It sits directly between the joystick direction decoder and `gameController`, replacing the ad-hoc debouncer on the `dir` path.

## Interface
- `STABLE_CYCLES`, default 1000000: cycles a synchronized code must hold unchanged to qualify (10 ms at 100 MHz); minimum 2.
- `REPEAT_CYCLES`, default 50000000: auto-repeat interval; only used when `DIR_AUTOREPEAT_EN` is defined.
- `clk` in 1: system clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dir_raw` in 3: raw direction code, asynchronous to `clk`. 0 up, 1 right, 2 down, 3 left, 4 none; 5–7 are treated as 4.
- `move_ready` in 1: the game controller can accept a move this cycle.
- `move_valid` out 1: a qualified move is pending.
- `move_dir` out 3: move direction 0–3 while `move_valid` is high; 4 otherwise.
- `neutral` out 1: high when the qualified stick state is neutral.

## Operation
- Input path:
  - `dir_raw` passes through a 2-flop synchronizer (reset value 4), then is mapped: 5–7 become 4.
  - A candidate register plus a stability counter follow the synchronizer. Any change of the synchronized code reloads the candidate and clears the counter.
  - The candidate is "qualified" in the cycle the counter reaches `STABLE_CYCLES-1`.
  - The counter saturates at that value; it never wraps.
- FSM states and transitions:
  - IDLE → PENDING when the candidate qualifies as 0–3. A qualified 4 stays in IDLE.
  - PENDING: `move_valid`=1 and `move_dir`=candidate. Both hold unchanged until `move_valid && move_ready`, then go to RELEASE.
  - RELEASE → IDLE when the candidate qualifies as 4.
  - A qualified different direction in RELEASE (no neutral in between) is ignored and issues no move.
- Input changes while in PENDING do not alter `move_dir`. The accepted move is the one that qualified.
- `neutral` is 1 in IDLE, and 0 in PENDING and RELEASE.
- Reset, including mid-PENDING, returns all state to IDLE and discards any pending move.

## Timing
- Reset values: `move_valid`=0, `move_dir`=4, `neutral`=1; synchronizer and candidate = 4; counter = 0.
- Latency:
  - A `dir_raw` value first sampled at edge N, and held, reaches the candidate at edge N+2.
  - `move_valid` rises after edge N+2+`STABLE_CYCLES`.
- Handshake:
  - Transfer occurs on a rising edge with `move_valid` and `move_ready` both high.
  - `move_valid` drops in the following cycle.
  - `move_ready` high with `move_valid` low has no effect.
  - `move_ready` may be held high permanently: each move is then valid for exactly 1 cycle.
- At most one move is outstanding; no queueing.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `DIR_AUTOREPEAT_EN`.
- Defined: while in RELEASE with the qualified candidate still equal to the last transferred direction, a repeat counter runs from the transfer edge.
  - On reaching `REPEAT_CYCLES-1`, the FSM re-enters PENDING with the same direction and the repeat counter clears.
  - Any candidate change clears the repeat counter.
- Not defined: no repeat counter exists. A held stick yields exactly one move.

## Test plan
Benches use `STABLE_CYCLES`=4 and `REPEAT_CYCLES`=16.
- Reset mid-PENDING:
  - Stimulus: assert `rst_n`=0 while `move_valid`=1.
  - Required: `move_valid`=0, `move_dir`=4, `neutral`=1 immediately (asynchronous), and they stay there until a new qualification.
- Clean press:
  - Stimulus: `dir_raw`=2 from edge 0, `move_ready`=1.
  - Required: `move_valid`=1 with `move_dir`=2 for exactly one cycle, after edge 6. No further moves until `dir_raw`=4 has held ≥6 cycles.
- Bounce:
  - Stimulus: `dir_raw` toggles 1/4 every 2 cycles for 40 cycles, then holds 1.
  - Required: no `move_valid` during the toggling; exactly one move with `move_dir`=1 after the hold qualifies.
- Backpressure:
  - Stimulus: qualify 3 with `move_ready`=0 for 20 cycles while `dir_raw` changes to 0.
  - Required: `move_valid` and `move_dir`=3 stay stable. Transfer occurs on the first `move_ready`=1 edge, and `move_dir`=3 is delivered.
- Direction change without neutral:
  - Stimulus: hold 0 until transferred, then switch `dir_raw` straight to 1 and hold.
  - Required: no second move. After `dir_raw`=4 for ≥6 cycles, then 1, a move with `move_dir`=1 issues.
- `DIR_AUTOREPEAT_EN`:
  - Stimulus: hold 1 for 60 cycles with `move_ready`=1.
  - Required: defined — moves at the qualify edge, then every 17 cycles (16 counted + 1 for PENDING), i.e. 4 moves. Undefined — exactly 1 move.

Source files
------------

// File: rtl/dir_qualifier.sv
// Joystick direction qualifier: synchronize, debounce and issue one move per deflection over valid/ready.
// Optional auto-repeat of a held direction when DIR_AUTOREPEAT_EN is defined.
module dir_qualifier #(
   parameter int STABLE_CYCLES = 1000000,
   parameter int REPEAT_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] dir_raw,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [2:0] move_dir,
   output logic       neutral
);

   localparam int             CW         = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [2:0]     DIR_NONE   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PENDING,
      S_RELEASE
   } state_t;

   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("dir_qualifier: STABLE_CYCLES must be at least 2");
   end

   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_cand;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   logic          r_valid;
   logic [2:0]    r_dir;
   logic          r_neutral;

   logic [2:0]    w_sync;
   logic          w_qual;

`ifdef DIR_AUTOREPEAT_EN
   localparam int            RW         = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] REPEAT_MAX = RW'(REPEAT_CYCLES - 1);

   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("dir_qualifier: REPEAT_CYCLES must be at least 2");
   end

   logic [RW-1:0] r_rep;
   logic [2:0]    r_last;
`else
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("dir_qualifier: REPEAT_CYCLES must be at least 2");
   end
`endif

   // Codes 5-7 are not real directions; fold them onto "none".
   assign w_sync = (r_sync2 > DIR_NONE) ? DIR_NONE : r_sync2;
   assign w_qual = (r_cnt == STABLE_MAX);

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= DIR_NONE;
         r_sync2 <= DIR_NONE;
         r_cand  <= DIR_NONE;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= dir_raw;
         r_sync2 <= r_sync1;
         if (w_sync != r_cand) begin
            r_cand <= w_sync;
            r_cnt  <= '0;
         end else if (!w_qual) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_valid   <= 1'b0;
         r_dir     <= DIR_NONE;
         r_neutral <= 1'b1;
`ifdef DIR_AUTOREPEAT_EN
         r_rep     <= '0;
         r_last    <= DIR_NONE;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_qual && r_cand != DIR_NONE) begin
                  r_state   <= S_PENDING;
                  r_valid   <= 1'b1;
                  r_dir     <= r_cand;
                  r_neutral <= 1'b0;
               end
            end
            S_PENDING: begin
               // Direction is frozen here; only the handshake moves us on.
               if (move_ready) begin
                  r_state <= S_RELEASE;
                  r_valid <= 1'b0;
                  r_dir   <= DIR_NONE;
`ifdef DIR_AUTOREPEAT_EN
                  r_last  <= r_dir;
                  r_rep   <= '0;
`endif
               end
            end
            S_RELEASE: begin
               if (w_qual && r_cand == DIR_NONE) begin
                  r_state   <= S_IDLE;
                  r_neutral <= 1'b1;
`ifdef DIR_AUTOREPEAT_EN
                  r_rep     <= '0;
               end else if (w_qual && r_cand == r_last) begin
                  if (r_rep == REPEAT_MAX) begin
                     r_state <= S_PENDING;
                     r_valid <= 1'b1;
                     r_dir   <= r_last;
                     r_rep   <= '0;
                  end else begin
                     r_rep <= r_rep + 1'b1;
                  end
               end else begin
                  r_rep <= '0;
`endif
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_valid   <= 1'b0;
               r_dir     <= DIR_NONE;
               r_neutral <= 1'b1;
            end
         endcase
      end
   end

   assign move_valid = r_valid;
   assign move_dir   = r_dir;
   assign neutral    = r_neutral;

endmodule

// File: tb/tb_dir_qualifier.sv
// Directed bench for dir_qualifier with STABLE_CYCLES=4, REPEAT_CYCLES=16.
// Expected move counts for the held-stick step follow DIR_AUTOREPEAT_EN.
module tb_dir_qualifier;

   logic       clk;
   logic       rst_n;
   logic [2:0] dir_raw;
   logic       move_ready;
   logic       move_valid;
   logic [2:0] move_dir;
   logic       neutral;

   int n_checks;
   int n_errors;
   int moves;
   int vcycles;
   int last_dir;
   int m0;
   int v0;

`ifdef DIR_AUTOREPEAT_EN
   localparam int HOLD_MOVES = 4;
`else
   localparam int HOLD_MOVES = 1;
`endif

   dir_qualifier #(
      .STABLE_CYCLES(4),
      .REPEAT_CYCLES(16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dir_raw   (dir_raw),
      .move_ready(move_ready),
      .move_valid(move_valid),
      .move_dir  (move_dir),
      .neutral   (neutral)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transfer monitor: counts completed handshakes and cycles with valid high.
   initial begin
      moves    = 0;
      vcycles  = 0;
      last_dir = 7;
   end
   always @(posedge clk) begin
      if (move_valid) vcycles = vcycles + 1;
      if (move_valid && move_ready) begin
         moves    = moves + 1;
         last_dir = int'(move_dir);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int v, input int d, input int n);
      check({tag, "_valid"}, int'(move_valid), v);
      check({tag, "_dir"}, int'(move_dir), d);
      check({tag, "_neutral"}, int'(neutral), n);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      dir_raw    = 3'd4;
      move_ready = 1'b0;

      // Reset state
      step(3);
      check_out("reset", 0, 4, 1);
      rst_n = 1'b1;
      step(2);
      check_out("idle", 0, 4, 1);

      // Clean press: dir 2, ready held high
      move_ready = 1'b1;
      dir_raw    = 3'd2;
      m0 = moves; v0 = vcycles;
      step(6);
      check_out("press_e5", 0, 4, 1);
      step(1);
      check_out("press_e6", 1, 2, 0);
      step(1);
      check_out("press_e7", 0, 4, 0);
      check("press_lastdir", last_dir, 2);
      step(10);
      check("press_moves", moves - m0, 1);
      check("press_vcycles", vcycles - v0, 1);
      check("press_release_neutral", int'(neutral), 0);
      dir_raw = 3'd4;
      step(8);
      check_out("press_back_idle", 0, 4, 1);

      // Bounce: toggle 1/4 every 2 cycles, then hold 1
      m0 = moves; v0 = vcycles;
      for (int i = 0; i < 20; i++) begin
         dir_raw = (i % 2 == 0) ? 3'd1 : 3'd4;
         step(2);
      end
      check("bounce_moves", moves - m0, 0);
      check("bounce_vcycles", vcycles - v0, 0);
      dir_raw = 3'd1;
      step(6);
      check("bounce_hold_e5", int'(move_valid), 0);
      step(1);
      check_out("bounce_hold_e6", 1, 1, 0);
      step(1);
      check("bounce_moves_after", moves - m0, 1);
      check("bounce_lastdir", last_dir, 1);
      dir_raw = 3'd4;
      step(8);
      check("bounce_neutral", int'(neutral), 1);

      // Backpressure: qualify 3, stick moves to 0 while ready is low
      move_ready = 1'b0;
      dir_raw    = 3'd3;
      m0 = moves;
      step(7);
      check_out("bp_qual", 1, 3, 0);
      dir_raw = 3'd0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("bp_hold_valid", int'(move_valid), 1);
         check("bp_hold_dir", int'(move_dir), 3);
      end
      check("bp_no_transfer", moves - m0, 0);
      move_ready = 1'b1;
      step(1);
      check("bp_valid_drop", int'(move_valid), 0);
      check("bp_moves", moves - m0, 1);
      check("bp_lastdir", last_dir, 3);
      step(8);
      check("bp_ignored_dir0", moves - m0, 1);
      dir_raw = 3'd4;
      step(8);
      check("bp_neutral", int'(neutral), 1);

      // Direction change without neutral
      dir_raw = 3'd0;
      m0 = moves;
      step(7);
      check_out("chg_qual", 1, 0, 0);
      step(1);
      check("chg_transfer", moves - m0, 1);
      dir_raw = 3'd1;
      step(12);
      check("chg_no_second", moves - m0, 1);
      check("chg_neutral_low", int'(neutral), 0);
      dir_raw = 3'd4;
      step(8);
      check("chg_neutral", int'(neutral), 1);
      dir_raw = 3'd1;
      step(6);
      check("chg_e5", int'(move_valid), 0);
      step(1);
      check_out("chg_e6", 1, 1, 0);
      step(1);
      check("chg_moves", moves - m0, 2);
      check("chg_lastdir", last_dir, 1);
      dir_raw = 3'd4;
      step(8);
      check("chg_back_idle", int'(neutral), 1);

      // Held stick: one move, or repeats every 17 cycles with auto-repeat
      dir_raw = 3'd1;
      m0 = moves; v0 = vcycles;
      step(60);
      check("hold_moves", moves - m0, HOLD_MOVES);
      check("hold_vcycles", vcycles - v0, HOLD_MOVES);
      dir_raw = 3'd4;
      step(20);
      check("hold_no_extra", moves - m0, HOLD_MOVES);
      check("hold_neutral", int'(neutral), 1);

      // Reset mid-PENDING
      move_ready = 1'b0;
      dir_raw    = 3'd2;
      step(7);
      check_out("rst_pending", 1, 2, 0);
      #2 rst_n = 1'b0;
      #1;
      check_out("rst_async", 0, 4, 1);
      step(2);
      check_out("rst_held", 0, 4, 1);
      #2 rst_n = 1'b1;
      step(6);
      check_out("rst_after_e5", 0, 4, 1);
      step(1);
      check_out("rst_requal", 1, 2, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
